// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcodes, FSM encodings and decode helpers
// for the MEM-stage load/store sequencer.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(input logic [5:0] op,
                                        input logic [1:0] off);
        logic half;
        logic word;
        half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word = (op == OP_LW) || (op == OP_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

    // Store data is replicated so every enabled lane sees the right value.
    function automatic logic [31:0] repl(input logic [5:0] op,
                                         input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        if (op == OP_SB) r = {4{wd[7:0]}};
        else if (op == OP_SH) r = {2{wd[15:0]}};
        return r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Combinational load extract: picks byte/half by offset
// and sign- or zero-extends to 32 bits.
module mem_access_ctrl_load_ext
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = word_i[8*off_i +: 8];
        half_w = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = word_i;
        unique case (1'b1)
            (opcode_i == OP_LB):  data_o = {{24{byte_w[7]}}, byte_w};
            (opcode_i == OP_LBU): data_o = {24'h0, byte_w};
            (opcode_i == OP_LH):  data_o = {{16{half_w[15]}}, half_w};
            (opcode_i == OP_LHU): data_o = {16'h0, half_w};
            default:              data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one req/ack bus cycle per
// access, store lane replication and held extended load data.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    output logic        bus_err,
    output logic [31:0] rdata_ext,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [5:0]    op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          aerr_q, aerr_d;
    logic          berr_q, berr_d;
    logic [31:0]   ext;

    mem_access_ctrl_load_ext u_load_ext (
        .opcode_i (op_q),
        .off_i    (addr_q[1:0]),
        .word_i   (mem_rdata),
        .data_o   (ext)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    addr_d  = addr;
                    be_d    = be;
                    wdata_d = repl(opcode, wdata);
                    cnt_d   = '0;
                    if (!is_load(opcode) && !is_store(opcode)) begin
                        done_d = 1'b1;
                    end else if (misaligned(opcode, addr[1:0])) begin
                        done_d = 1'b1;
                        aerr_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Ack beats a timeout landing in the same cycle.
                if (mem_ack) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    if (is_load(op_q)) rdata_d = ext;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign busy      = (state_q == ST_REQ) || (state_q == ST_FIN);
    assign done      = done_q;
    assign addr_err  = aerr_q;
    assign bus_err   = berr_q;
    assign rdata_ext = rdata_q;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = (state_q == ST_REQ) && is_store(op_q);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a
// transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int TO = 16;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic        bus_err;
    logic [31:0] rdata_ext;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .busy      (busy),
        .done      (done),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .rdata_ext (rdata_ext),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_is_load(input logic [5:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic bit m_is_store(input logic [5:0] op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic bit m_bad_align(input logic [5:0] op,
                                       input logic [31:0] a);
        if (op inside {LH, LHU, SH}) return (a % 2) != 0;
        if (op inside {LW, SW}) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_store_data(input logic [5:0] op,
                                                 input logic [31:0] w);
        if (op == SB) return (w & 32'hFF) * 32'h01010101;
        if (op == SH) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v;
        v = w;
        if (op inside {LB, LBU}) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (op == LB && v >= 128) v = v - 256;
        end else if (op inside {LH, LHU}) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (op == LH && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // wait_n = ack wait cycles; wait_n >= TO means no ack at all.
    task automatic xact(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] bev,
                        input int wait_n, input logic [31:0] rd,
                        input bit noise);
        bit acked;
        start  = 1'b1;
        opcode = op;
        addr   = a;
        wdata  = wd;
        be     = bev;
        cyc();
        start  = 1'b0;
        opcode = 6'($urandom);
        addr   = $urandom;
        wdata  = $urandom;
        be     = 4'($urandom);
        if (!m_is_load(op) && !m_is_store(op)) begin
            chk("nop_done", 32'(done), 1);
            chk("nop_aerr", 32'(addr_err), 0);
            chk("nop_req", 32'(mem_req), 0);
            cyc();
            chk("nop_done_off", 32'(done), 0);
            chk("nop_rdata", rdata_ext, exp_rdata);
            return;
        end
        if (m_bad_align(op, a)) begin
            chk("al_done", 32'(done), 1);
            chk("al_aerr", 32'(addr_err), 1);
            chk("al_req", 32'(mem_req), 0);
            chk("al_busy", 32'(busy), 0);
            cyc();
            chk("al_done_off", 32'(done), 0);
            chk("al_req2", 32'(mem_req), 0);
            chk("al_rdata", rdata_ext, exp_rdata);
            return;
        end
        acked = 1'b0;
        for (int i = 0; i < TO && !acked; i++) begin
            chk("req", 32'(mem_req), 1);
            chk("busy", 32'(busy), 1);
            chk("done_low", 32'(done), 0);
            if (i == 0) begin
                chk("we", 32'(mem_we), 32'(m_is_store(op)));
                chk("maddr", mem_addr, a & 32'hFFFFFFFC);
                chk("mbe", 32'(mem_be), 32'(bev));
                chk("mwdata", mem_wdata, m_store_data(op, wd));
            end
            if (noise) begin
                start  = 1'($urandom);
                opcode = SW;
                addr   = $urandom;
            end
            if (i == wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
                acked     = 1'b1;
            end else begin
                mem_rdata = $urandom;
            end
            cyc();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
        start = 1'b0;
        if (acked) begin
            if (m_is_load(op)) exp_rdata = m_load(op, a, rd);
            chk("fin_done", 32'(done), 1);
            chk("fin_busy", 32'(busy), 1);
            chk("fin_berr", 32'(bus_err), 0);
            chk("fin_req", 32'(mem_req), 0);
            chk("rdata", rdata_ext, exp_rdata);
            if (noise) mem_ack = 1'($urandom);
            cyc();
            mem_ack = 1'b0;
            chk("post_busy", 32'(busy), 0);
        end else begin
            chk("to_done", 32'(done), 1);
            chk("to_berr", 32'(bus_err), 1);
            chk("to_req", 32'(mem_req), 0);
            chk("to_busy", 32'(busy), 0);
            cyc();
        end
        chk("post_done", 32'(done), 0);
        chk("post_rdata", rdata_ext, exp_rdata);
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] op;
        int w;
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00, 6'h0F};
        rst_n     = 1'b0;
        start     = 1'b0;
        opcode    = '0;
        addr      = '0;
        wdata     = '0;
        be        = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_rdata = '0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_rdata", rdata_ext, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mwdata", mem_wdata, 0);
        chk("rst_mbe", 32'(mem_be), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        xact(SW, 32'h10, 32'h11223344, 4'hF, 0, 32'h0, 1'b0);
        xact(SB, 32'h13, 32'h000000AB, 4'h8, 1, 32'h0, 1'b0);
        xact(LB, 32'h2, 32'h0, 4'h4, 3, 32'h0080FF00, 1'b0);
        xact(LBU, 32'h2, 32'h0, 4'h4, 3, 32'h0080FF00, 1'b0);
        xact(LH, 32'h1, 32'h0, 4'h3, 0, 32'hDEADBEEF, 1'b0);
        xact(LH, 32'h6, 32'h0, 4'hC, 2, 32'h8001_7FFF, 1'b0);
        xact(LW, 32'h20, 32'h0, 4'hF, TO, 32'h0, 1'b0);
        xact(LW, 32'h24, 32'h0, 4'hF, TO - 1, 32'hCAFEF00D, 1'b0);

        // Reset asserted while a request is outstanding.
        start  = 1'b1;
        opcode = SW;
        addr   = 32'h40;
        wdata  = 32'h5555AAAA;
        be     = 4'hF;
        cyc();
        start = 1'b0;
        chk("mid_req", 32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rdata", rdata_ext, 0);
        exp_rdata = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        for (int k = 0; k < 150; k++) begin
            op = ops[$urandom_range(0, 9)];
            w  = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 5);
            xact(op, $urandom, $urandom, 4'($urandom), w, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
                cyc();
                mem_ack = 1'b0;
                chk("idle_ack", rdata_ext, exp_rdata);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
